// File: rtl/ycbcr_block_buffer_if.sv
// Block-stream handshake from the YCbCr block buffer to the DCT stage.
interface ycbcr_block_buffer_if #(
    parameter int PIX_W = 6
);
    logic signed [7:0]  blk_data;
    logic [1:0]         blk_comp;
    logic [PIX_W-1:0]   blk_idx;
    logic               blk_last;
    logic               blk_valid;
    logic               blk_ready;

    modport master (output blk_data, blk_comp, blk_idx, blk_last, blk_valid, input blk_ready);
    modport slave  (input blk_data, blk_comp, blk_idx, blk_last, blk_valid, output blk_ready);
endinterface

// File: rtl/ycbcr_block_buffer.sv
// Collects pixel-interleaved Y/Cb/Cr samples into 8x8 ping-pong banks and
// replays each bank component-planar to the DCT over valid/ready.
module ycbcr_block_buffer #(
    parameter int FRAC_BITS = 8,
    parameter int BLK_PIX   = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic signed [23:0]   din,
    input  logic                 d_qual,
    input  logic                 sof,
    output logic                 buf_full,
    output logic                 ovf,
    ycbcr_block_buffer_if.master blk
);
    localparam int PIX_W = $clog2(BLK_PIX);
    localparam int AW    = PIX_W + 3;
    localparam logic [PIX_W-1:0]   PIX_MAX  = PIX_W'(BLK_PIX - 1);
    localparam logic signed [24:0] RND_HALF = 25'sd1 <<< (FRAC_BITS - 1);

    function automatic logic signed [7:0] round_sat(input logic signed [23:0] x);
        logic signed [24:0] t;
        t = ($signed({x[23], x}) + RND_HALF) >>> FRAC_BITS;
        if (t > 25'sd127)
            return 8'sd127;
        else if (t < -25'sd128)
            return 8'sh80;
        else
            return t[7:0];
    endfunction

    typedef enum logic {IDLE, SEND} rd_state_t;

    // Address is {bank, comp, pix}; comp value 3 is never used.
    logic signed [7:0]  mem [0:(2**AW)-1];
    logic [1:0]         wr_comp, wc;
    logic [PIX_W-1:0]   wr_pix, wp;
    logic               wr_bank, wr_en, fill;
    logic [1:0]         full, set_mask, clr_mask;

    rd_state_t          state;
    logic               rd_bank, rd_done;
    logic signed [7:0]  data_p1;
    logic [1:0]         comp_p1, nxt_comp;
    logic [PIX_W-1:0]   idx_p1, nxt_idx;
    logic               last_p1, vld_p1;

    always_comb begin
        wc       = sof ? 2'd0 : wr_comp;
        wp       = sof ? '0 : wr_pix;
        wr_en    = d_qual && !buf_full && !full[wr_bank];
        fill     = wr_en && (wc == 2'd2) && (wp == PIX_MAX);
        set_mask = {fill & wr_bank, fill & ~wr_bank};
        nxt_idx  = idx_p1 + PIX_W'(1);
        nxt_comp = (idx_p1 == PIX_MAX) ? comp_p1 + 2'd1 : comp_p1;
        rd_done  = (state == SEND) && blk.blk_ready && last_p1;
        clr_mask = {rd_done & rd_bank, rd_done & ~rd_bank};
    end

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[{wr_bank, wc, wp}] <= round_sat(din);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_comp  <= 2'd0;
            wr_pix   <= '0;
            wr_bank  <= 1'b0;
            full     <= 2'b00;
            buf_full <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wc == 2'd2) begin
                    wr_comp <= 2'd0;
                    wr_pix  <= wp + PIX_W'(1);
                end else begin
                    wr_comp <= wc + 2'd1;
                    wr_pix  <= wp;
                end
                if (fill)
                    wr_bank <= ~wr_bank;
            end else if (sof) begin
                wr_comp <= 2'd0;
                wr_pix  <= '0;
            end
            if (d_qual && !wr_en)
                ovf <= 1'b1;
            // A fill and a drain in the same cycle always hit different banks.
            full     <= (full | set_mask) & ~clr_mask;
            buf_full <= &full;
        end
    end

    // Output stage p1: registered sample, held while the DCT stalls.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            comp_p1 <= 2'd0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state   <= SEND;
                        vld_p1  <= 1'b1;
                        comp_p1 <= 2'd0;
                        idx_p1  <= '0;
                        last_p1 <= 1'b0;
                        data_p1 <= mem[{rd_bank, 2'd0, {PIX_W{1'b0}}}];
                    end
                end
                SEND: begin
                    if (blk.blk_ready) begin
                        if (last_p1) begin
                            state   <= IDLE;
                            vld_p1  <= 1'b0;
                            last_p1 <= 1'b0;
                            rd_bank <= ~rd_bank;
                        end else begin
                            comp_p1 <= nxt_comp;
                            idx_p1  <= nxt_idx;
                            last_p1 <= (nxt_comp == 2'd2) && (nxt_idx == PIX_MAX);
                            data_p1 <= mem[{rd_bank, nxt_comp, nxt_idx}];
                        end
                    end
                end
            endcase
        end
    end

    assign blk.blk_data  = data_p1;
    assign blk.blk_comp  = comp_p1;
    assign blk.blk_idx   = idx_p1;
    assign blk.blk_last  = last_p1;
    assign blk.blk_valid = vld_p1;
endmodule

// File: doc/ycbcr_block_buffer.md
Name: ycbcr_block_buffer

Overview:
- Downstream neighbour of the RGB-to-YCbCr converter.
- Consumes its serial fixed-point sample stream: one d_qual pulse per sample, ordered Y, Cb, Cr per pixel.
- Rounds and saturates each sample to signed 8 bit and stores 64 pixels (one 8x8 block, row-major) into a ping-pong buffer.
- Replays each stored block component-planar (64 Y, then 64 Cb, then 64 Cr) to the DCT stage over a valid/ready handshake.

Parameters:
- FRAC_BITS, 8, number of fractional bits in the 24-bit two's-complement input sample.
- BLK_PIX, 64, pixels per block; must be a power of 2.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  24  fixed-point sample from converter; valid only while d_qual=1.
- d_qual  input  1  sample strobe; three strobes form one pixel (Y, Cb, Cr).
- sof  input  1  start-of-frame pulse; clears write-side counters.
- buf_full  output  1  both banks occupied; upstream must hold rgb_valid low.
- ovf  output  1  sticky: a sample arrived while buf_full=1.
- blk_data  output  8  signed sample to DCT.
- blk_comp  output  2  component of blk_data: 0=Y, 1=Cb, 2=Cr.
- blk_idx  output  6  pixel index 0..63 within block.
- blk_last  output  1  high with the final sample of a block (comp 2, idx 63).
- blk_valid  output  1  blk_* outputs are valid.
- blk_ready  input  1  DCT accepts the sample.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; banks empty; write bank 0, read bank 0; comp and pixel counters 0; ovf cleared.
- Conversion (combinational, on din):
  - t = din + 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Saturate t to [-128, 127].
- Write side, on each d_qual=1 with buf_full=0:
  - Store the converted byte at [wr_bank][comp][pix].
  - Advance comp 0 to 1 to 2 to 0; pix increments when comp wraps from 2 to 0.
  - On the Cr write at pix=BLK_PIX-1: set full[wr_bank], toggle wr_bank, pix wraps to 0.
- d_qual=1 with buf_full=1:
  - Sample dropped; counters frozen; ovf set and held until reset.
- sof=1: comp and pix cleared to 0 that cycle.
  - Bank full flags and read side untouched; a partially written bank is discarded.
  - sof together with d_qual: sof wins, and the sample is written at comp 0, pix 0, with counters then advancing to comp 1.
- buf_full = full[0] & full[1], registered; it asserts the cycle after the second bank fills.
- Read FSM:
  - IDLE: when full[rd_bank]=1, go to SEND the next cycle with comp=0, idx=0, blk_valid=1.
  - SEND: on blk_valid & blk_ready, advance idx, then comp (idx wraps 63 to 0).
  - SEND, on the handshake of the last sample: clear full[rd_bank], toggle rd_bank, return to IDLE, and drop blk_valid the next cycle.
  - Minimum one idle cycle between blocks.
- Output registers:
  - blk_data, blk_comp, blk_idx and blk_last are registered.
  - They hold stable while blk_valid=1 and blk_ready=0.
  - blk_valid never drops without a handshake.
- Simultaneous events:
  - Write-side set of full[a] and read-side clear of full[b] in the same cycle both take effect.
  - a=b cannot occur, because the write side never targets a full bank.
- Latency: first blk_valid 2 cycles after the final Cr strobe of a block when the read side is idle.
- Throughput:
  - Read drains 192 samples in 192 cycles at blk_ready=1.
  - Write fills a bank in 192 strobes (256 cycles at the converter's 4-cycle-per-pixel rate).
  - So sustained operation never fills both banks when blk_ready=1.

Test Plan:
- Rounding/saturation: din=0x000180 (1.5) -> 2; 0x00FF80 (255.5) -> 127; 0xFF7F00 (-129.0) -> -128; 0xFFFF80 (-0.5) -> 0.
- One block, blk_ready=1: 64 pixels with Y=pix, Cb=-pix/2, Cr=63-pix -> 192 outputs ordered comp 0/1/2 with idx 0..63, blk_data matching, blk_last only on comp 2 idx 63.
- Backpressure: blk_ready toggled randomly and held low 20 cycles mid-block -> blk_* stable while stalled; no sample lost or repeated.
- Overflow: blk_ready=0, write 3 blocks -> buf_full rises after block 2; block 3 strobes dropped; ovf=1; releasing blk_ready yields blocks 1 and 2 intact and buf_full falls after block 1 drains.
- sof mid-block: 10 pixels, sof, then 64 pixels -> only one block output, containing the post-sof data.
- Reset mid-transfer: assert rst_n=0 during SEND at idx 30 -> blk_valid=0, buf_full=0, ovf=0 immediately; a new block afterwards starts at comp 0, idx 0 from bank 0.
